// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per clock through a registered carry.
// Define CHUNKED_SERIAL_ADDER_SUB_EN to add a 'sub' port that computes A - B.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, shadow_q, shadow_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [CHUNK-1:0] a_c, b_c;
    logic [CHUNK:0]   chunk_res;
    logic             last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
        end
    end

    assign last = (idx_q == IDXW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        a_c       = '0;
        b_c       = '0;
        chunk_res = '0;
        if (state_q == IDLE && start) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
            // Subtraction as A + ~B + 1; overflow then naturally sees the inverted B MSB.
            if (sub) begin
                b_d     = ~b;
                carry_d = 1'b1;
            end
`endif
        end else if (state_q == RUN) begin
            for (int i = 0; i < NCHUNK; i++) begin
                if (idx_q == IDXW'(i)) begin
                    a_c = a_q[i*CHUNK +: CHUNK];
                    b_c = b_q[i*CHUNK +: CHUNK];
                end
            end
            chunk_res = {1'b0, a_c} + {1'b0, b_c} + (CHUNK+1)'(carry_q);
            for (int i = 0; i < NCHUNK; i++) begin
                if (idx_q == IDXW'(i)) shadow_d[i*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
            end
            carry_d = chunk_res[CHUNK];
            idx_d   = idx_q + IDXW'(1);
            if (last) begin
                idx_d  = '0;
                sum_d  = shadow_d;
                cout_d = chunk_res[CHUNK];
                ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (shadow_d[WIDTH-1] != a_q[WIDTH-1]);
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        ready = (state_q == IDLE);
    end

    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed-vector bench for chunked_serial_adder (default WIDTH=16, CHUNK=4).
module tb_chunked_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    logic        sub = 1'b0;
`endif
    logic        ready, done, cout, overflow;
    logic [15:0] sum;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .ready(ready), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drive a request now (away from an edge); returns #1 after the accepting edge.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s);
        start = 1'b1; a = av; b = bv; cin = c;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        sub = s;
`endif
        @(posedge clk); #1;
        start = 1'b0; a = 16'h5A5A; b = 16'hC3C3; cin = ~c;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        sub = ~s;
`endif
    endtask

    // Count edges until done; checks latency, ready low while busy, outputs held.
    task automatic wait_done(input string tag, input int exp_lat);
        logic [15:0] prev = sum;
        bit held = 1, rdy_low = 1;
        int lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (ready !== 1'b0) rdy_low = 0;
            @(posedge clk); #1;
            if (done === 1'b1) begin lat = k; break; end
            if (sum !== prev) held = 0;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_ready_low"}, rdy_low, 1);
        chk({tag, "_held"}, held, 1);
        chk({tag, "_ready_done"}, ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic c, input logic s, input logic [15:0] es,
                          input logic ec, input logic eo);
        issue(av, bv, c, s);
        wait_done(tag, 4);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, overflow, eo);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        bit no_done;
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", ready, 1);
        chk("idle_done", done, 0);

        run_op("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("8000_x2", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("mixed",   16'h1357, 16'h2468, 1'b1, 1'b0, 16'h37C0, 1'b0, 1'b0);

        // Busy start is ignored; start during done cycle is accepted.
        @(negedge clk);
        issue(16'h1234, 16'h1111, 1'b1, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_ign", 2);
        chk("busy_ign_sum", sum, 16'h2346);
        chk("busy_ign_cout", cout, 0);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0);
        chk("b2b_accept", ready, 0);
        wait_done("b2b", 4);
        chk("b2b_sum", sum, 16'h0002);

        // Reset during the second RUN cycle aborts the operation.
        @(negedge clk);
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_sum", sum, 0);
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        no_done = 1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) no_done = 0;
        end
        chk("abort_no_done", no_done, 1);
        run_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        run_op("sub_5m7",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_8000m1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub0_add",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Multi-cycle, parametrised successor of the single-bit half/full adder cells.
- Adds two WIDTH-bit operands CHUNK bits per clock, rippling the carry through a registered carry flop between chunks.
- Trades latency for area in datapaths where a full-width ripple adder would not meet timing.
- Start/ready/done handshake toward a controlling FSM; results held stable until the next operation completes.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock. NCHUNK = WIDTH/CHUNK (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  operand A, sampled on accepted start
- b  input  WIDTH  operand B, sampled on accepted start
- cin  input  1  carry-in, sampled on accepted start
- ready  output  1  high when idle and able to accept start
- done  output  1  one-cycle pulse: sum/cout/overflow just updated
- sum  output  WIDTH  result, registered
- cout  output  1  carry out of MSB, registered
- overflow  output  1  two's-complement signed overflow, registered

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; ready=1; done=0; sum=0; cout=0; overflow=0.
  - Internal operand, carry, chunk-index and shadow registers cleared.
- States:
  - IDLE -> RUN on an edge where start=1 and ready=1. At that edge a, b, cin are latched, idx=0, carry=cin.
  - RUN: each edge adds chunk idx (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK) of the latched A and B plus the carry register.
    - Chunk sum is written into the shadow register; carry is updated; idx increments.
  - At the edge processing idx=NCHUNK-1: state -> IDLE.
    - sum <= full shadow value including the final chunk.
    - cout <= final carry.
    - overflow <= (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]).
    - done <= 1.
- done is high for exactly one cycle and is deasserted on the following edge.
- ready = (state==IDLE). It is 0 throughout RUN and 1 during the done cycle.
- Latency: done is high in the cycle beginning NCHUNK edges after the accepting edge. Default configuration: 4.
- Throughput: one operation per NCHUNK+1 cycles. A start asserted during the done cycle is accepted (back-to-back).
- start while busy (ready=0) is ignored: no queuing, no effect on the in-flight operation.
- a/b/cin may change freely after the accepting edge; only latched values are used.
- sum/cout/overflow change only on completion edges or reset. Partial results are never visible on the outputs.
- Degenerate CHUNK=WIDTH (NCHUNK=1): single RUN cycle; done one edge after acceptance.
- Reset asserted mid-RUN aborts the operation: outputs go to reset values and no done pulse is produced.
- Illegal WIDTH % CHUNK != 0: elaboration-time error via generate-time check.

Optional Feature:
- Macro: CHUNKED_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands on the accepting edge.
  - sub=1 computes A - B: latched B is bitwise inverted and the initial carry is forced to 1; cin is ignored.
  - cout=1 means no borrow.
  - overflow uses the inverted B MSB in its formula.
  - sub=0 behaves exactly as the base block.
- Not defined: no sub port; add-only behaviour as above.

Test Plan:
- Reset, then idle -> ready=1, done=0, sum=0x0000, cout=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0, start pulse -> done high exactly 4 cycles after the accepting edge; sum=0x0000, cout=1, overflow=0; ready=0 for the 4 RUN cycles.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1.
- Accept a=0x1234, b=0x1111, cin=1.
  - Assert start with a=0xAAAA two cycles later -> ignored; sum=0x2346.
  - Start in the done cycle with a=0x0001, b=0x0001, cin=0 -> accepted; next done gives sum=0x0002.
- Start a=0x00FF, b=0x0001; pull rst_n low on the 2nd RUN cycle -> outputs reset immediately, no done pulse; the next start completes normally.
- With CHUNKED_SERIAL_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0.
- With CHUNKED_SERIAL_ADDER_SUB_EN: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, overflow=1.
